// File: rtl/tx_lane_distribution.sv
// tx_lane_distribution: round-robin distribution of 66b coded blocks onto PCS lanes with alignment-marker round insertion.
// Ports:
//    i_clock   - system clock, rising edge
//    i_reset   - asynchronous active-low reset
//    i_enable  - global enable; when low, all state holds
//    i_valid   - i_block is valid
//    i_block   - coded block from the scrambler
//    o_ready   - block accepted this cycle when i_valid is high
//    i_am_bus  - per-lane alignment markers, lane n at [n*66 +: 66]
//    o_data    - registered lane bus, lane n at [n*66 +: 66]
//    o_valid   - one-cycle pulse: o_data holds a complete round
//    o_am_flag - the current o_data round is an alignment-marker round
module tx_lane_distribution #(
   parameter int LEN_CODED_BLOCK = 66,
   parameter int N_LANES         = 20,
   parameter int AM_PERIOD       = 16383,
   parameter int NB_LANE_CNT     = $clog2(N_LANES),
   parameter int NB_AM_CNT       = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1,
   parameter int NB_BUS          = N_LANES * LEN_CODED_BLOCK
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_enable,
   input  logic                       i_valid,
   input  logic [LEN_CODED_BLOCK-1:0] i_block,
   output logic                       o_ready,
   input  logic [NB_BUS-1:0]          i_am_bus,
   output logic [NB_BUS-1:0]          o_data,
   output logic                       o_valid,
   output logic                       o_am_flag
);
   typedef enum logic {FILL, AM_INS} state_t;
   localparam logic [NB_LANE_CNT-1:0] LANE_LAST  = NB_LANE_CNT'(N_LANES - 1);
   localparam logic [NB_LANE_CNT-1:0] LANE_ONE   = NB_LANE_CNT'(1);
   localparam logic [NB_AM_CNT-1:0]   ROUND_LAST = NB_AM_CNT'(AM_PERIOD - 1);
   localparam logic [NB_AM_CNT-1:0]   ROUND_ONE  = NB_AM_CNT'(1);
   state_t                   state_q, state_d;
   logic [NB_LANE_CNT-1:0]   lane_cnt_q, lane_cnt_d;
   logic [NB_AM_CNT-1:0]     round_cnt_q, round_cnt_d;
   logic [NB_BUS-1:0]        buf_q, buf_d;
   logic [NB_BUS-1:0]        data_q, data_d;
   logic                     valid_q, valid_d;
   logic                     am_flag_q, am_flag_d;
   logic                     accept, round_done, am_ins;
   assign o_ready    = i_enable && (state_q == FILL);
   assign accept     = i_valid && o_ready;
   assign round_done = accept && (lane_cnt_q == LANE_LAST);
   assign am_ins     = i_enable && (state_q == AM_INS);
   always_comb begin
      buf_d = buf_q;
      for (int n = 0; n < N_LANES; n++)
         if (accept && lane_cnt_q == NB_LANE_CNT'(n))
            buf_d[n*LEN_CODED_BLOCK +: LEN_CODED_BLOCK] = i_block;
      lane_cnt_d  = round_done ? '0 : (accept ? lane_cnt_q + LANE_ONE : lane_cnt_q);
      round_cnt_d = !round_done ? round_cnt_q
                  : (round_cnt_q == ROUND_LAST ? '0 : round_cnt_q + ROUND_ONE);
      state_d = state_q;
      if (round_done && round_cnt_q == ROUND_LAST)
         state_d = AM_INS;
      else if (am_ins)
         state_d = FILL;
      // buf_d already carries the current block, so the closing round is complete here
      data_d    = round_done ? buf_d : (am_ins ? i_am_bus : data_q);
      valid_d   = round_done || am_ins;
      am_flag_d = am_ins;
   end
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= FILL;
         lane_cnt_q  <= '0;
         round_cnt_q <= '0;
         buf_q       <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         am_flag_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_cnt_q  <= lane_cnt_d;
         round_cnt_q <= round_cnt_d;
         buf_q       <= buf_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         am_flag_q   <= am_flag_d;
      end
   end
   assign o_data    = data_q;
   assign o_valid   = valid_q;
   assign o_am_flag = am_flag_q;
endmodule

// File: tb/tb_tx_lane_distribution.sv
// tb_tx_lane_distribution: scoreboard and vector-table bench for tx_lane_distribution.
module tb_tx_lane_distribution;
   localparam int L   = 66;
   localparam int N   = 20;
   localparam int AMP = 2;
   localparam int NB  = N * L;
   typedef struct {
      logic [NB-1:0] data;
      logic          am;
      int            cyc;
   } exp_t;
   typedef struct {
      logic         en;
      logic         vld;
      logic [L-1:0] blk;
      logic         exp_ready;
   } vec_t;
   logic          i_clock = 1'b0;
   logic          i_reset = 1'b0;
   logic          i_enable = 1'b0;
   logic          i_valid = 1'b0;
   logic [L-1:0]  i_block = '0;
   logic [NB-1:0] i_am_bus;
   logic          o_ready;
   logic [NB-1:0] o_data;
   logic          o_valid;
   logic          o_am_flag;
   tx_lane_distribution #(.AM_PERIOD(AMP)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
      .i_block(i_block), .o_ready(o_ready), .i_am_bus(i_am_bus), .o_data(o_data),
      .o_valid(o_valid), .o_am_flag(o_am_flag)
   );
   always #5 i_clock = ~i_clock;
   int cyc = 0;
   always @(posedge i_clock) cyc <= cyc + 1;
   int n_vec = 0;
   int n_err = 0;
   exp_t q[$];
   logic [L-1:0] m_buf [N];
   int   m_slot, m_round;
   logic m_pend;
   logic last_ready, last_acc;
   vec_t tbl [60];
   task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   task automatic model_clear();
      m_slot = 0;
      m_round = 0;
      m_pend = 1'b0;
      q.delete();
      for (int n = 0; n < N; n++) m_buf[n] = '0;
   endtask
   // Drive one cycle of stimulus, check o_ready, advance the reference model.
   task automatic step(input logic en, input logic vld, input logic [L-1:0] blk);
      logic er;
      logic [NB-1:0] bus;
      i_enable = en;
      i_valid = vld;
      i_block = blk;
      #1;
      last_ready = o_ready;
      er = en && !m_pend;
      chk("ready", {65'd0, o_ready}, {65'd0, er});
      last_acc = vld && er;
      if (last_acc) begin
         m_buf[m_slot] = blk;
         m_slot++;
         if (m_slot == N) begin
            for (int n = 0; n < N; n++) bus[n*L +: L] = m_buf[n];
            q.push_back('{bus, 1'b0, cyc + 1});
            m_slot = 0;
            m_round++;
            if (m_round == AMP) begin
               m_round = 0;
               m_pend = 1'b1;
            end
         end
      end else if (en && m_pend) begin
         q.push_back('{i_am_bus, 1'b1, cyc + 1});
         m_pend = 1'b0;
      end
      @(negedge i_clock);
   endtask
   // Offer consecutive blocks base+k with i_valid held until cnt are accepted.
   task automatic feed(input int cnt, input logic [L-1:0] base, output int lo);
      int k = 0;
      int g = 0;
      lo = 0;
      while (k < cnt && g < 4 * cnt + 8) begin
         step(1'b1, 1'b1, base + L'(k));
         if (!last_ready) lo++;
         if (last_acc) k++;
         g++;
      end
      chk("feed_count", L'(k), L'(cnt));
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
   endtask
   task automatic do_reset();
      i_valid = 1'b0;
      #2 i_reset = 1'b0;
      #1;
      chk("rst_data_zero", {65'd0, |o_data}, '0);
      chk("rst_valid", {65'd0, o_valid}, '0);
      chk("rst_am_flag", {65'd0, o_am_flag}, '0);
      model_clear();
      @(negedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b1;
   endtask
   always @(negedge i_clock) begin : monitor
      exp_t e;
      int bad;
      logic due;
      due = q.size() > 0 && q[0].cyc == cyc;
      chk("o_valid", {65'd0, o_valid}, {65'd0, due});
      if (!o_valid) chk("am_flag_idle", {65'd0, o_am_flag}, '0);
      if (due) begin
         e = q.pop_front();
         chk("o_am_flag", {65'd0, o_am_flag}, {65'd0, e.am});
         bad = -1;
         for (int n = 0; n < N; n++)
            if (bad < 0 && o_data[n*L +: L] !== e.data[n*L +: L]) bad = n;
         n_vec++;
         if (bad >= 0) begin
            n_err++;
            $display("FAIL o_data lane %0d: got %0h want %0h (cycle %0d)", bad,
                     o_data[bad*L +: L], e.data[bad*L +: L], cyc);
         end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
         n_vec++;
         n_err++;
         $display("FAIL missed_round: expected at cycle %0d, none by cycle %0d", q[0].cyc, cyc);
         void'(q.pop_front());
      end
   end
   initial begin
      int lo;
      int plan;
      int k;
      int g;
      plan = 0;
      for (int i = 0; i < 60; i++) begin
         tbl[i].en = !(i >= 6 && i < 11);
         tbl[i].vld = (plan < 19) && ($urandom_range(0, 2) != 0);
         tbl[i].blk = 66'h1000 + L'(41 + plan);
         tbl[i].exp_ready = tbl[i].en;
         if (tbl[i].en && tbl[i].vld) plan++;
      end
      for (int n = 0; n < N; n++) i_am_bus[n*L +: L] = 66'h2_0000_0000_0000_0100 + L'(n);
      model_clear();
      @(negedge i_clock);
      chk("init_data_zero", {65'd0, |o_data}, '0);
      chk("init_valid", {65'd0, o_valid}, '0);
      chk("init_am_flag", {65'd0, o_am_flag}, '0);
      i_reset = 1'b1;
      // one plain round, lane n = n
      feed(20, '0, lo);
      chk("t2_ready_low", L'(lo), '0);
      idle(2);
      // reset in the middle of a round
      feed(5, 66'h3_0000, lo);
      do_reset();
      idle(1);
      chk("rst_ready_first", {65'd0, last_ready}, 66'd1);
      // two data rounds, AM round, then block 40 into slot 0
      feed(41, 66'h1000, lo);
      chk("t3_ready_low", L'(lo), 66'd1);
      // gaps and an enable-low window completing that round
      for (int i = 0; i < 60; i++) begin
         step(tbl[i].en, tbl[i].vld, tbl[i].blk);
         chk("tbl_ready", {65'd0, last_ready}, {65'd0, tbl[i].exp_ready});
      end
      k = 41 + plan;
      g = 0;
      while (m_slot != 0 && g < 40) begin
         step(1'b1, 1'b1, 66'h1000 + L'(k));
         if (last_acc) k++;
         g++;
      end
      chk("t4_round_closed", L'(m_slot), '0);
      idle(2);
      // partial round discarded by reset
      feed(7, 66'hdead_0000, lo);
      do_reset();
      feed(20, 66'h5000, lo);
      idle(2);
      // held block across the AM cycle lands once in lane 0
      feed(39, 66'h6000, lo);
      chk("t6_ready_low", L'(lo), 66'd1);
      idle(3);
      chk("queue_drained", L'(q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/tx_lane_distribution.md
Name: tx_lane_distribution

Overview:
- Transmit-side counterpart of the receive lane reorder in the 100GbE PCS datapath.
- Accepts one 66b coded block per handshake and distributes consecutive blocks round-robin onto N_LANES PCS lanes: block k goes to lane k mod N_LANES.
- When a full round is collected, emits it as one registered wide bus.
- After every AM_PERIOD data rounds, inserts one alignment-marker round and back-pressures the upstream source for that cycle.

Parameters:
- LEN_CODED_BLOCK, 66, width of one coded block.
- N_LANES, 20, number of PCS lanes.
- AM_PERIOD, 16383, data rounds between alignment-marker rounds (must be >= 1).
- NB_LANE_CNT, $clog2(N_LANES), lane slot counter width.
- NB_AM_CNT, $clog2(AM_PERIOD), round counter width (minimum 1).
- NB_BUS, N_LANES*LEN_CODED_BLOCK, lane bus width.

Ports:
- i_clock, in, 1, system clock, rising edge.
- i_reset, in, 1, reset; asynchronous, active-low.
- i_enable, in, 1, global enable; when low, all state holds.
- i_valid, in, 1, i_block is valid.
- i_block, in, LEN_CODED_BLOCK, coded block from the scrambler.
- o_ready, out, 1, block accepted this cycle when i_valid is high.
- i_am_bus, in, NB_BUS, per-lane alignment markers; lane n occupies bits [n*66 +: 66]; static for the whole AM cycle.
- o_data, out, NB_BUS, lane bus; lane n occupies bits [n*66 +: 66].
- o_valid, out, 1, o_data holds a complete round (one-cycle pulse).
- o_am_flag, out, 1, the current o_data round is an alignment-marker round.

Behaviour:
- Reset (i_reset low, asynchronous):
  - o_data = 0, o_valid = 0, o_am_flag = 0.
  - lane_cnt = 0, round_cnt = 0, assembly buffer = 0, state = FILL.
  - Any partial round is discarded.
- FSM has two states, FILL and AM_INS.
- o_ready is combinational: o_ready = i_enable && (state == FILL).
- Accept condition: accept = i_valid && o_ready.
- FILL, on accept:
  - i_block is written into buffer slot lane_cnt, and lane_cnt increments.
  - If lane_cnt == N_LANES-1:
    - o_data is loaded with the buffer contents plus the current block.
    - o_valid = 1 and o_am_flag = 0 on the next cycle.
    - lane_cnt wraps to 0.
    - If round_cnt == AM_PERIOD-1: round_cnt goes to 0 and state goes to AM_INS. Otherwise round_cnt increments.
- AM_INS, with i_enable high:
  - o_data is loaded from i_am_bus; o_valid = 1 and o_am_flag = 1 on the next cycle.
  - state returns to FILL.
  - o_ready is low for exactly this one cycle.
  - The AM round therefore appears on the cycle directly after the last data round of the period.
- Latency: o_valid rises one cycle after the accept of the N_LANES-th block of a round.
- o_valid and o_am_flag are deasserted on every cycle without a round completion or AM emission. o_data holds its last value.
- No output back-pressure: downstream must absorb every o_valid pulse.
- i_enable low:
  - No accept; lane_cnt, round_cnt, buffer and state are all held.
  - o_valid = 0 and o_am_flag = 0.
  - An AM_INS state stays pending until i_enable returns high.
- i_valid without o_ready (AM_INS cycle): the block is not consumed. Upstream holds it, and it is accepted next cycle into slot 0.
- Width rules: lane_cnt and round_cnt compare against N_LANES-1 and AM_PERIOD-1 exactly. Out-of-range values are never reached.
- Gaps on i_valid within a round are legal; slot order is preserved.

Test Plan:
1. Reset low mid-stream, then released -> o_data = 0, o_valid = 0, o_am_flag = 0, o_ready = 1 on the first enabled cycle.
2. 20 back-to-back accepts with i_block = k (k = 0..19), AM_PERIOD = 16383 -> exactly one o_valid pulse, one cycle after the 20th accept, with lane n = n; o_am_flag = 0.
3. AM_PERIOD = 2, 40 consecutive blocks, i_am_bus lane n = 66'h2_0000_0000_0000_0100 + n:
   - o_valid pulses for round 0 and round 1, then on the next cycle o_am_flag = 1 and o_data = i_am_bus.
   - o_ready is low for exactly 1 cycle.
   - Block 40 lands in slot 0 of the following round.
4. Random i_valid gaps and i_enable low for 5 cycles inside a round -> slot assignment unchanged vs. the gap-free run, and no spurious o_valid.
5. Reset low after 7 accepted blocks -> the next 20 accepts form a clean round starting at slot 0; the first 7 blocks never appear on o_data.
6. i_valid high with a held block during the AM_INS cycle -> the block is not lost or duplicated and appears exactly once, in lane 0 of the next data round.
